// File: rtl/dice_bus_pkg.sv
// Shared definitions for the dice chip register-bank bus: widths, arbiter
// FSM state encoding and port identifiers.
package dice_bus_pkg;

    localparam int REGBUS_ADDR_W = 4;
    localparam int REGBUS_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } regbus_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // The port that is not `id`.
    function automatic logic other_port(input logic id);
        return (id == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/regbus_rr_pick.sv
// Combinational two-way winner selection for the register-bank arbiter.
// A lock_force request keeps the last winner on the bus if it is still
// requesting; otherwise ties go to port A (fixed priority) or to the port
// that was not granted last (round-robin).
module regbus_rr_pick
    import dice_bus_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    input  logic fixed_prio,
    input  logic lock_force,
    output logic win_valid,
    output logic win_id
);

    logic last_req;

    assign last_req = (last_grant == PORT_A) ? req_a : req_b;

    // Pick the winner among the current requesters.
    always_comb begin
        win_valid = req_a | req_b;
        win_id    = PORT_A;
        if (lock_force && last_req) begin
            win_id = last_grant;
        end else if (req_a && req_b) begin
            win_id = fixed_prio ? PORT_A : other_port(last_grant);
        end else if (req_b) begin
            win_id = PORT_B;
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Two-port arbiter sharing the dice register bank between the I2C slave
// (port A) and on-chip logic (port B). One command is issued every two
// cycles: winner chosen in IDLE, bank strobed in ISSUE, ack the cycle after.
// Optional burst locking is built when REGBUS_ARB_LOCK_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; a winner's command is registered onto bus_*
// ISSUE | bus_en/gnt high for one cycle, bank read data captured
module regbus_arbiter
    import dice_bus_pkg::*;
#(
    parameter int ADDR_W     = REGBUS_ADDR_W,
    parameter int DATA_W     = REGBUS_DATA_W,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
`ifdef REGBUS_ARB_LOCK_EN
    input  logic              lock_a,
    input  logic              lock_b,
`endif
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    if (MAX_BURST < 1) begin : g_max_burst_chk
        $error("regbus_arbiter: MAX_BURST must be at least 1");
    end

    regbus_state_e     state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_grant_q, last_grant_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic win_valid;
    logic win_id;
    logic lock_force;

`ifdef REGBUS_ARB_LOCK_EN
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    logic [BCNT_W-1:0] burst_q, burst_d;
    logic              lock_last;
    logic              lock_win;

    assign lock_last = (last_grant_q == PORT_A) ? lock_a : lock_b;
    assign lock_win  = (win_id == PORT_A) ? lock_a : lock_b;
    // Only a back-to-back request (made in the ack cycle) may extend a burst.
    assign lock_force = (ack_a_q | ack_b_q) && lock_last
                        && (burst_q < BCNT_W'(MAX_BURST));
`else
    assign lock_force = 1'b0;
`endif

    regbus_rr_pick u_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO != 0),
        .lock_force (lock_force),
        .win_valid  (win_valid),
        .win_id     (win_id)
    );

    // State, bus command and per-port response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            winner_q     <= PORT_A;
            last_grant_q <= PORT_B;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

`ifdef REGBUS_ARB_LOCK_EN
    // Consecutive locked beats of the current burst owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    // Count beats on each grant; a new owner or a dropped lock restarts.
    always_comb begin
        burst_d = lock_last ? burst_q : '0;
        if (state_q == IDLE && win_valid) begin
            if (!lock_win) begin
                burst_d = '0;
            end else if (win_id == last_grant_q && burst_q != '0) begin
                burst_d = (burst_q == BCNT_W'(MAX_BURST)) ? burst_q : burst_q + 1'b1;
            end else begin
                burst_d = BCNT_W'(1);
            end
        end
    end
`endif

    // Next-state and command/response logic.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d      = ISSUE;
                    winner_d     = win_id;
                    last_grant_d = win_id;
                    if (win_id == PORT_A) begin
                        bus_we_d    = we_a;
                        bus_addr_d  = addr_a;
                        bus_wdata_d = wdata_a;
                    end else begin
                        bus_we_d    = we_b;
                        bus_addr_d  = addr_b;
                        bus_wdata_d = wdata_b;
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (winner_q == PORT_A) begin
                    ack_a_d   = 1'b1;
                    rdata_a_d = bus_we_q ? '0 : bus_rdata;
                end else begin
                    ack_b_d   = 1'b1;
                    rdata_b_d = bus_we_q ? '0 : bus_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_en    = (state_q == ISSUE);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign gnt_a     = bus_en && (winner_q == PORT_A);
    assign gnt_b     = bus_en && (winner_q == PORT_B);
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: a round-robin instance with a small
// bank model, plus a fixed-priority instance for the tie-break check.
// Lock steps are compiled in when REGBUS_ARB_LOCK_EN is defined.
module tb_regbus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, ack_a, gnt_b, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic       bus_en, bus_we;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic [7:0] mem [16];
`ifdef REGBUS_ARB_LOCK_EN
    logic       lock_a, lock_b;
`endif

    logic       req_a_f, req_b_f;
    logic       gnt_a_f, ack_a_f, gnt_b_f, ack_b_f;
    logic [7:0] rdata_a_f, rdata_b_f;
    logic       bus_en_f, bus_we_f;
    logic [3:0] bus_addr_f;
    logic [7:0] bus_wdata_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bank model: address 9 is a read-only status register returning 0xC3.
    always @(posedge clk) if (bus_en && bus_we) mem[bus_addr] <= bus_wdata;
    assign bus_rdata = (bus_addr == 4'd9) ? 8'hC3 : mem[bus_addr];

    regbus_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .ack_b(ack_b), .rdata_b(rdata_b),
`ifdef REGBUS_ARB_LOCK_EN
        .lock_a(lock_a), .lock_b(lock_b),
`endif
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    regbus_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .req_a(req_a_f), .we_a(1'b0), .addr_a(4'd1), .wdata_a(8'h00),
        .gnt_a(gnt_a_f), .ack_a(ack_a_f), .rdata_a(rdata_a_f),
        .req_b(req_b_f), .we_b(1'b0), .addr_b(4'd2), .wdata_b(8'h00),
        .gnt_b(gnt_b_f), .ack_b(ack_b_f), .rdata_b(rdata_b_f),
`ifdef REGBUS_ARB_LOCK_EN
        .lock_a(1'b0), .lock_b(1'b0),
`endif
        .bus_en(bus_en_f), .bus_we(bus_we_f), .bus_addr(bus_addr_f),
        .bus_wdata(bus_wdata_f), .bus_rdata({4'h0, bus_addr_f})
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  exp_ga, exp_gb, exp_aa, exp_ab, exp_gaf;
    logic [11:0] exp_lga, exp_lgb;

    initial begin
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        req_a_f = 1'b0; req_b_f = 1'b0;
`ifdef REGBUS_ARB_LOCK_EN
        lock_a = 1'b0; lock_b = 1'b0;
`endif
        tick; tick;
        chk("rst_bus_en", bus_en, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rdata_b", rdata_b, 0);
        rst = 1'b0;
        tick;
        chk("idle_bus_en", bus_en, 0);

        // Single write on A
        we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'h5A; req_a = 1'b1;
        tick;
        chk("wrA_gnt_a", gnt_a, 1);
        chk("wrA_bus_en", bus_en, 1);
        chk("wrA_bus_we", bus_we, 1);
        chk("wrA_bus_addr", bus_addr, 3);
        chk("wrA_bus_wdata", bus_wdata, 8'h5A);
        chk("wrA_gnt_b", gnt_b, 0);
        chk("wrA_ack_early", ack_a, 0);
        tick;
        chk("wrA_ack_a", ack_a, 1);
        chk("wrA_gnt_in_ack", gnt_a, 0);
        chk("wrA_rdata_zero", rdata_a, 0);
        chk("wrA_bank", mem[3], 8'h5A);
        req_a = 1'b0;
        tick;
        chk("wrA_ack_done", ack_a, 0);
        chk("wrA_addr_hold", bus_addr, 3);
        chk("wrA_we_hold", bus_we, 1);

        // Single read on B of status address 9
        we_b = 1'b0; addr_b = 4'd9; req_b = 1'b1;
        tick;
        chk("rdB_gnt_b", gnt_b, 1);
        chk("rdB_bus_we", bus_we, 0);
        chk("rdB_bus_addr", bus_addr, 9);
        tick;
        chk("rdB_ack_b", ack_b, 1);
        chk("rdB_rdata_b", rdata_b, 8'hC3);
        req_b = 1'b0;
        tick; tick;
        chk("rdB_ack_done", ack_b, 0);
        chk("rdB_rdata_hold", rdata_b, 8'hC3);

        // Contention, both held: RR alternates A,B; fixed priority gives A
        exp_ga = 8'b0001_0001; exp_gb = 8'b0100_0100;
        exp_aa = 8'b0010_0010; exp_ab = 8'b1000_1000;
        exp_gaf = 8'b0101_0101;
        we_a = 1'b0; addr_a = 4'd3; we_b = 1'b0; addr_b = 4'd9;
        req_a = 1'b1; req_b = 1'b1; req_a_f = 1'b1; req_b_f = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick;
            chk($sformatf("rr_gnt_a_c%0d", c + 1), gnt_a, exp_ga[c]);
            chk($sformatf("rr_gnt_b_c%0d", c + 1), gnt_b, exp_gb[c]);
            chk($sformatf("rr_ack_a_c%0d", c + 1), ack_a, exp_aa[c]);
            chk($sformatf("rr_ack_b_c%0d", c + 1), ack_b, exp_ab[c]);
            chk($sformatf("fp_gnt_a_c%0d", c + 1), gnt_a_f, exp_gaf[c]);
            chk($sformatf("fp_gnt_b_c%0d", c + 1), gnt_b_f, 0);
            if (c == 1) chk("rr_rdata_a", rdata_a, 8'h5A);
            if (c == 3) chk("rr_rdata_b", rdata_b, 8'hC3);
            if (c == 7) begin
                req_a = 1'b0; req_b = 1'b0; req_a_f = 1'b0; req_b_f = 1'b0;
            end
        end
        tick;
        chk("rr_quiet_gnt_a", gnt_a, 0);
        chk("rr_quiet_gnt_b", gnt_b, 0);
        chk("rr_quiet_bus_en", bus_en, 0);

        // Back-to-back writes on A with B idle
        we_a = 1'b1; addr_a = 4'd5; wdata_a = 8'h11; req_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            chk($sformatf("b2b_gnt_a_c%0d", c), gnt_a, (c % 2 == 1) ? 1 : 0);
            chk($sformatf("b2b_ack_a_c%0d", c), ack_a, (c % 2 == 0) ? 1 : 0);
            chk($sformatf("b2b_gnt_b_c%0d", c), gnt_b, 0);
            if (c == 6) req_a = 1'b0;
        end
        tick;
        chk("b2b_quiet", gnt_a, 0);
        chk("b2b_bank", mem[5], 8'h11);

        // Reset during an A ISSUE cycle; last_grant must return to B
        we_a = 1'b1; addr_a = 4'd7; wdata_a = 8'h77; req_a = 1'b1;
        tick;
        chk("rstiss_gnt_a", gnt_a, 1);
        rst = 1'b1;
        tick;
        chk("rstiss_bank", mem[7], 8'h77);
        chk("rstiss_ack_a", ack_a, 0);
        chk("rstiss_bus_en", bus_en, 0);
        chk("rstiss_gnt_a_after", gnt_a, 0);
        chk("rstiss_bus_addr", bus_addr, 0);
        chk("rstiss_bus_we", bus_we, 0);
        rst = 1'b0;
        we_a = 1'b0; addr_a = 4'd3; we_b = 1'b0; addr_b = 4'd9;
        req_a = 1'b1; req_b = 1'b1;
        tick;
        chk("rstiss_tie_gnt_a", gnt_a, 1);
        chk("rstiss_tie_gnt_b", gnt_b, 0);
        tick;
        chk("rstiss_tie_ack_a", ack_a, 1);
        chk("rstiss_tie_rdata_a", rdata_a, 8'h5A);
        req_a = 1'b0; req_b = 1'b0;
        tick;

`ifdef REGBUS_ARB_LOCK_EN
        // A locks while B requests: four A beats, then B, then A
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_lga = 12'b0100_0101_0101;
        exp_lgb = 12'b0001_0000_0000;
        we_a = 1'b1; addr_a = 4'd2; wdata_a = 8'hAA; lock_a = 1'b1; req_a = 1'b1;
        we_b = 1'b0; addr_b = 4'd9; req_b = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick;
            chk($sformatf("lock_gnt_a_c%0d", c + 1), gnt_a, exp_lga[c]);
            chk($sformatf("lock_gnt_b_c%0d", c + 1), gnt_b, exp_lgb[c]);
            if (c == 11) begin
                req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0;
            end
        end
        tick;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
